// File: rtl/pipe_adder_pkg.sv
// ---------------------------------------------------------------------------
// pipe_adder_pkg
//   Shared definitions for the pipelined ripple-carry adder:
//     - OVF_UNSIGNED / OVF_SIGNED : values of the SIGNED parameter
//     - chunk_width()            : bits handled by one pipeline stage
//     - params_ok()              : elaboration-time legality check
// ---------------------------------------------------------------------------
package pipe_adder_pkg;

    // Overflow rule selectors for the SIGNED parameter.
    localparam int OVF_UNSIGNED = 0;
    localparam int OVF_SIGNED   = 1;

    // Each stage adds WIDTH/STAGES bits.
    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    // The operand must split evenly into stages and be at least two bits
    // wide, so the signed rule always has a bit below the sign bit.
    function automatic bit params_ok(input int width, input int stages,
                                     input int signed_mode);
        return (width >= 2) && (stages >= 1) && ((width % stages) == 0) &&
               ((signed_mode == OVF_UNSIGNED) || (signed_mode == OVF_SIGNED));
    endfunction

endpackage

// File: rtl/pipe_adder_add_stage.sv
// ---------------------------------------------------------------------------
// add_stage
//   One pipeline stage of pipe_adder: a CHUNK-bit ripple adder plus the
//   stage's valid and carry registers and its handshake logic. The summed
//   chunk is returned combinationally; the parent stores it alongside the
//   rest of the in-flight word when 'load' is high.
//
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     up_valid      upstream has data for this stage
//     up_ready      this stage can take upstream data this cycle
//     a_chunk       operand A chunk for this stage
//     b_chunk       operand B chunk for this stage
//     carry_in      carry into bit 0 of this chunk
//     down_ready    downstream can take this stage's contents
//     valid         stage holds a live operation
//     carry         registered carry out of this chunk
//     msb_carry     registered carry into the chunk MSB (LAST only, else 0)
//     sum_chunk     combinational chunk sum
//     load          transfer into this stage happens on the next edge
// ---------------------------------------------------------------------------
module add_stage
    import pipe_adder_pkg::*;
#(
    parameter int CHUNK = 4,
    parameter bit LAST  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [CHUNK-1:0] a_chunk,
    input  logic [CHUNK-1:0] b_chunk,
    input  logic             carry_in,
    input  logic             down_ready,
    output logic             valid,
    output logic             carry,
    output logic             msb_carry,
    output logic [CHUNK-1:0] sum_chunk,
    output logic             load
);

    logic [CHUNK:0] total;

    assign total     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_in};
    assign sum_chunk = total[CHUNK-1:0];

    // An empty stage always accepts; a full one only if it can move on.
    assign up_ready = !valid || down_ready;
    assign load     = up_ready && up_valid;

    // Valid follows upstream whenever the stage is ready, so bubbles pass
    // through; the carry only changes on a real transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            carry <= 1'b0;
        end else begin
            if (up_ready) begin
                valid <= up_valid;
            end
            if (load) begin
                carry <= total[CHUNK];
            end
        end
    end

    // The carry into the word's MSB is recovered as a ^ b ^ sum at that
    // bit, which works for any chunk width including a single bit.
    if (LAST) begin : g_msb_tap
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                msb_carry <= 1'b0;
            end else if (load) begin
                msb_carry <= a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ total[CHUNK-1];
            end
        end
    end else begin : g_no_tap
        assign msb_carry = 1'b0;
    end

endmodule

// File: rtl/pipe_adder.sv
// ---------------------------------------------------------------------------
// pipe_adder
//   Pipelined ripple-carry adder. The operands are split into STAGES chunks
//   that are added LSB first, one chunk per stage, with the carry handed
//   between stage registers. Valid/ready handshake at both ends.
//
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     in_valid / in_ready  operand handshake
//     a, b, cin            operands and carry-in
//     out_valid / out_ready result handshake
//     sum                  a + b + cin modulo 2^WIDTH
//     cout                 carry out of bit WIDTH-1
//     ovf                  overflow (cout when SIGNED=0, two's complement
//                          overflow when SIGNED=1)
// ---------------------------------------------------------------------------
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int SIGNED = OVF_UNSIGNED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES, SIGNED)) begin : g_param_check
        $error("pipe_adder: WIDTH must be >= 2 and divisible by STAGES, SIGNED must be 0 or 1");
    end

    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_carry;
    logic [STAGES-1:0] stage_load;
    logic [STAGES-1:0] down_ready;
    logic              stage_up_ready [STAGES];
    logic              msb_tap        [STAGES];
    logic [CHUNK-1:0]  stage_sum      [STAGES];

    // word_q[k]: sum chunks 0..k below, operand A chunks k+1.. above.
    // bop_q[k]:  operand B, of which chunks k+1.. are still needed.
    logic [WIDTH-1:0]  word_q [STAGES];
    logic [WIDTH-1:0]  bop_q  [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             up_valid;
        logic             up_carry;
        logic [WIDTH-1:0] up_word;
        logic [WIDTH-1:0] up_b;
        logic [WIDTH-1:0] merged;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_carry = cin;
            assign up_word  = a;
            assign up_b     = b;
        end else begin : g_body
            assign up_valid = stage_valid[k-1];
            assign up_carry = stage_carry[k-1];
            assign up_word  = word_q[k-1];
            assign up_b     = bop_q[k-1];
        end

        // The ready chain is unrolled: stage k's downstream is ready if the
        // consumer is ready or any later stage is empty. Using the registered
        // valid bits directly keeps the chain free of combinational feedback.
        if (k == STAGES - 1) begin : g_tail
            assign down_ready[k] = out_ready;
        end else begin : g_inner
            assign down_ready[k] = out_ready || !(&stage_valid[STAGES-1:k+1]);
        end

        add_stage #(
            .CHUNK (CHUNK),
            .LAST  (k == STAGES - 1)
        ) u_add_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .up_valid   (up_valid),
            .up_ready   (stage_up_ready[k]),
            .a_chunk    (up_word[k*CHUNK +: CHUNK]),
            .b_chunk    (up_b[k*CHUNK +: CHUNK]),
            .carry_in   (up_carry),
            .down_ready (down_ready[k]),
            .valid      (stage_valid[k]),
            .carry      (stage_carry[k]),
            .msb_carry  (msb_tap[k]),
            .sum_chunk  (stage_sum[k]),
            .load       (stage_load[k])
        );

        // Replace this stage's operand chunk with its freshly added sum.
        always_comb begin
            merged                      = up_word;
            merged[k*CHUNK +: CHUNK]    = stage_sum[k];
        end

        // Skew and sum-alignment registers move only on a real transfer so
        // bubbles leave the data path untouched.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q[k] <= '0;
                bop_q[k]  <= '0;
            end else if (stage_load[k]) begin
                word_q[k] <= merged;
                bop_q[k]  <= up_b;
            end
        end
    end

    assign in_ready  = stage_up_ready[0];
    assign out_valid = stage_valid[STAGES-1];
    assign sum       = word_q[STAGES-1];
    assign cout      = stage_carry[STAGES-1];
    assign ovf       = (SIGNED == OVF_SIGNED) ? (msb_tap[STAGES-1] ^ stage_carry[STAGES-1])
                                              : stage_carry[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_pipe_adder
//   Four instances share the operand bus:
//     0: WIDTH 16, STAGES 4,  unsigned
//     1: WIDTH 16, STAGES 4,  signed
//     2: WIDTH 16, STAGES 1,  unsigned
//     3: WIDTH 16, STAGES 16, unsigned
//   Expected results are queued at acceptance; a monitor pops them when
//   the matching instance hands a result over.
// ---------------------------------------------------------------------------
module tb_pipe_adder;
    import pipe_adder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [3:0]  cout_v;
    logic [3:0]  ovf_v;
    logic [15:0] sum_v [4];

    int checks = 0;
    int errors = 0;

    // Expected {cout, ovf, sum} per instance.
    logic [17:0] q0 [$];
    logic [17:0] q1 [$];
    logic [17:0] q2 [$];
    logic [17:0] q3 [$];

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(16), .STAGES(4), .SIGNED(OVF_UNSIGNED)) dut_u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));

    pipe_adder #(.WIDTH(16), .STAGES(4), .SIGNED(OVF_SIGNED)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));

    pipe_adder #(.WIDTH(16), .STAGES(1), .SIGNED(OVF_UNSIGNED)) dut_u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

    pipe_adder #(.WIDTH(16), .STAGES(16), .SIGNED(OVF_UNSIGNED)) dut_u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .sum(sum_v[3]), .cout(cout_v[3]), .ovf(ovf_v[3]));

    // Reference: plain 17-bit addition; signed overflow from operand signs.
    function automatic logic [17:0] refAdd(input logic [15:0] x, input logic [15:0] y,
                                           input logic c, input bit sgn);
        logic [16:0] s;
        logic        v;
        s = {1'b0, x} + {1'b0, y} + {16'b0, c};
        v = sgn ? ((x[15] == y[15]) && (s[15] != x[15])) : s[16];
        return {s[16], v, s[15:0]};
    endfunction

    function automatic int stagesOf(input int id);
        case (id)
            2:       return 1;
            3:       return 16;
            default: return 4;
        endcase
    endfunction

    function automatic void pushExp(input int id, input logic [17:0] v);
        case (id)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            2:       q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endfunction

    function automatic int qSize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [17:0] popExp(input int id);
        case (id)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            2:       return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    function automatic void clearExp(input int id);
        case (id)
            0:       q0.delete();
            1:       q1.delete();
            2:       q2.delete();
            default: q3.delete();
        endcase
    endfunction

    function automatic int qTotal();
        return q0.size() + q1.size() + q2.size() + q3.size();
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic scoreOutput(input int id);
        logic [17:0] act;
        logic [17:0] expv;
        act = {cout_v[id], ovf_v[id], sum_v[id]};
        if (qSize(id) == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_result dut%0d actual=%0h required=none", id, act);
        end else begin
            expv = popExp(id);
            checkOutput($sformatf("result_dut%0d", id), 32'(act), 32'(expv));
        end
    endtask

    // Monitor: compare every handed-over result against the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (out_valid[d] && out_ready[d]) begin
                scoreOutput(d);
            end
        end
    end

    // Present one operation and hold it until accepted; returns the number
    // of cycles in_ready was low. Called at posedge+1, returns at posedge+1.
    task automatic applyStimulus(input int id, input logic [15:0] va, input logic [15:0] vb,
                                 input logic vc, input logic [17:0] expv, output int waited);
        a            = va;
        b            = vb;
        cin          = vc;
        in_valid[id] = 1'b1;
        waited       = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready[id]) begin
                pushExp(id, expv);
                @(posedge clk);
                #1;
                break;
            end
            waited++;
            if (waited >= 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout dut%0d actual=no_ready required=ready", id);
                in_valid[id] = 1'b0;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idleInput(input int id);
        in_valid[id] = 1'b0;
    endtask

    // out_valid must rise exactly STAGES cycles after acceptance, for one cycle.
    task automatic latencyCheck(input int id);
        for (int n = 1; n <= stagesOf(id) + 1; n++) begin
            @(negedge clk);
            checkOutput($sformatf("latency_dut%0d_cycle%0d", id, n), 32'(out_valid[id]),
                        (n == stagesOf(id)) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (qTotal() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain_pending", 32'(qTotal()), 32'd0);
    endtask

    // Three ops in flight, one-cycle reset, then a fresh op must come out on time.
    task automatic resetMidFlight(input int id);
        int w;
        applyStimulus(id, 16'h0101, 16'h0202, 1'b0, refAdd(16'h0101, 16'h0202, 1'b0, 1'b0), w);
        applyStimulus(id, 16'h1010, 16'h2020, 1'b1, refAdd(16'h1010, 16'h2020, 1'b1, 1'b0), w);
        applyStimulus(id, 16'hF00F, 16'h0FF0, 1'b1, refAdd(16'hF00F, 16'h0FF0, 1'b1, 1'b0), w);
        idleInput(id);
        rst_n = 1'b0;
        clearExp(id);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("flush_out_valid_dut%0d", id), 32'(out_valid[id]), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(id, 16'hABCD, 16'h1111, 1'b1, 18'h0BCDF, w);
        idleInput(id);
        latencyCheck(id);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          waited;
        int          waits [8];
        logic [15:0] av;

        // Reset with in_valid asserted and unknown operands.
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        out_ready = 4'hF;
        a         = 'x;
        b         = 'x;
        cin       = 1'bx;
        repeat (3) @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'hF);
        checkOutput("reset_sum", 32'(sum_v[0]), 32'd0);
        checkOutput("reset_cout", 32'(cout_v), 32'd0);
        checkOutput("reset_ovf", 32'(ovf_v), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 4'h0;
        rst_n    = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'hF);
        for (int i = 0; i < 10; i++) begin
            checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        // Single op: wrap to zero with carry out.
        applyStimulus(0, 16'hFFFF, 16'h0001, 1'b0, 18'h30000, waited);
        idleInput(0);
        latencyCheck(0);

        // Hand-computed vectors, back to back.
        applyStimulus(0, 16'h1234, 16'h4321, 1'b1, 18'h05556, waited);
        applyStimulus(0, 16'hFFFF, 16'h0000, 1'b1, 18'h30000, waited);
        applyStimulus(0, 16'h8000, 16'h8000, 1'b0, 18'h30000, waited);
        idleInput(0);
        waitDrain();

        // Stream of eight ops with no stalls.
        for (int i = 0; i < 8; i++) begin
            av = 16'(i) * 16'h1111;
            applyStimulus(0, av, 16'h0F0F, 1'(i), refAdd(av, 16'h0F0F, 1'(i), 1'b0), waited);
            checkOutput($sformatf("stream_in_ready_op%0d", i), 32'(waited), 32'd0);
        end
        idleInput(0);
        waitDrain();

        // Backpressure: consumer stalls for six cycles while ops arrive.
        out_ready[0] = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    av = 16'hF000 + 16'(i) * 16'h0123;
                    applyStimulus(0, av, 16'h1F0F, ~1'(i), refAdd(av, 16'h1F0F, ~1'(i), 1'b0), waited);
                    waits[i] = waited;
                end
                idleInput(0);
            end
            begin
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    if (c >= 4) begin
                        checkOutput($sformatf("stall_out_valid_c%0d", c), 32'(out_valid[0]), 32'd1);
                        checkOutput($sformatf("stall_in_ready_c%0d", c), 32'(in_ready[0]), 32'd0);
                        checkOutput($sformatf("stall_hold_c%0d", c),
                                    32'({cout_v[0], ovf_v[0], sum_v[0]}), 32'h30F10);
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready[0] = 1'b1;
            end
        join
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("bp_wait_op%0d", i), 32'(waits[i]), (i == 4) ? 32'd2 : 32'd0);
        end
        waitDrain();

        // Two's-complement overflow rule.
        applyStimulus(1, 16'h7FFF, 16'h0001, 1'b0, 18'h18000, waited);
        applyStimulus(1, 16'hFFFF, 16'hFFFF, 1'b0, 18'h2FFFE, waited);
        applyStimulus(1, 16'h8000, 16'hFFFF, 1'b0, 18'h37FFF, waited);
        applyStimulus(1, 16'h1234, 16'h0001, 1'b1, 18'h01236, waited);
        idleInput(1);
        waitDrain();

        // Reset while results are in flight, for three pipeline depths.
        resetMidFlight(0);
        resetMidFlight(2);
        resetMidFlight(3);

        // Carry must ripple through every stage of the deep and shallow pipes.
        applyStimulus(3, 16'hFFFF, 16'h0001, 1'b0, 18'h30000, waited);
        idleInput(3);
        applyStimulus(2, 16'hFFFF, 16'h0001, 1'b0, 18'h30000, waited);
        idleInput(2);
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
